// File: rtl/bb_thread_sched.sv
// Basic-block thread scheduler.
// Keeps a saturating count of ready threads per basic block (BB). On a choose request it
// grants a batch of up to BATCH threads from one BB, picked either by lowest index or by
// round-robin starting after the previously granted BB. A write posted in the same cycle
// as a choose is visible to that choose.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   wr_en      post one ready thread to BB wr_sel
//   wr_sel     target BB of the write (values >= BBS are ignored)
//   choose_en  request a dispatch decision this cycle
//   bb_to_run  registered index of the last granted BB
//   run_count  registered number of threads granted with bb_to_run
//   run_valid  one-cycle pulse, a grant was made on the previous edge
//   empty      all registered counters are zero
//   overflow   sticky, a write hit a saturated counter
module bb_thread_sched #(
  parameter int unsigned BBS     = 32,
  parameter int unsigned LOG_BBS = 5,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned BATCH   = 4,
  parameter int unsigned RR_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [LOG_BBS-1:0] wr_sel,
  input  logic               choose_en,
  output logic [LOG_BBS-1:0] bb_to_run,
  output logic [CNT_W-1:0]   run_count,
  output logic               run_valid,
  output logic               empty,
  output logic               overflow
);

  localparam logic [CNT_W-1:0]   CntMax  = '1;
  localparam logic [CNT_W-1:0]   BatchW  = CNT_W'(BATCH);
  localparam logic [LOG_BBS-1:0] LastRst = LOG_BBS'(BBS - 1);

  logic [CNT_W-1:0]   cnt_q [BBS];
  logic [CNT_W-1:0]   cnt_d [BBS];
  logic [CNT_W-1:0]   cnt_w [BBS];  // post-write counts seen by the selector
  logic [LOG_BBS-1:0] bb_q, bb_d;
  logic [CNT_W-1:0]   run_count_q, run_count_d;
  logic               run_valid_q, run_valid_d;
  logic               overflow_q, overflow_d;
  logic [LOG_BBS-1:0] last_q, last_d;

  logic               wr_hit;
  logic               sat_hit;
  logic               found;
  logic               grant;
  logic [LOG_BBS-1:0] cand;
  logic [CNT_W-1:0]   cand_cnt;
  logic [CNT_W-1:0]   grant_n;
  int unsigned        idx;

  // Write path: apply the post, or flag a drop on a saturated counter.
  always_comb begin
    wr_hit  = wr_en && (32'(wr_sel) < BBS);
    sat_hit = 1'b0;
    for (int i = 0; i < BBS; i++) begin
      cnt_w[i] = cnt_q[i];
      if (wr_hit && (wr_sel == LOG_BBS'(i))) begin
        if (cnt_q[i] == CntMax) begin
          sat_hit = 1'b1;
        end else begin
          cnt_w[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Candidate selection over the post-write counts.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    if (RR_MODE == 0) begin
      // Scan downward so the lowest non-empty index wins last.
      for (int i = BBS - 1; i >= 0; i--) begin
        if (cnt_w[i] != '0) begin
          found = 1'b1;
          cand  = LOG_BBS'(i);
        end
      end
    end else begin
      // Rotate: last+1 .. last+BBS, so the last granted BB is tried last.
      for (int unsigned k = 1; k <= BBS; k++) begin
        idx = 32'(last_q) + k;
        if (idx >= BBS) idx = idx - BBS;
        if (!found && (cnt_w[LOG_BBS'(idx)] != '0)) begin
          found = 1'b1;
          cand  = LOG_BBS'(idx);
        end
      end
    end
  end

  // Grant sizing and next-state.
  always_comb begin
    cand_cnt = cnt_w[cand];
    grant_n  = (cand_cnt < BatchW) ? cand_cnt : BatchW;
    grant    = choose_en && found;

    for (int i = 0; i < BBS; i++) begin
      cnt_d[i] = cnt_w[i];
      if (grant && (cand == LOG_BBS'(i))) begin
        cnt_d[i] = cnt_w[i] - grant_n;
      end
    end

    run_valid_d = grant;
    bb_d        = grant ? cand : bb_q;
    last_d      = grant ? cand : last_q;
    overflow_d  = overflow_q | sat_hit;
    if (grant) begin
      run_count_d = grant_n;
    end else if (choose_en) begin
      run_count_d = '0;
    end else begin
      run_count_d = run_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BBS; i++) cnt_q[i] <= '0;
      bb_q        <= '0;
      run_count_q <= '0;
      run_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      last_q      <= LastRst;
    end else begin
      for (int i = 0; i < BBS; i++) cnt_q[i] <= cnt_d[i];
      bb_q        <= bb_d;
      run_count_q <= run_count_d;
      run_valid_q <= run_valid_d;
      overflow_q  <= overflow_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < BBS; i++) begin
      if (cnt_q[i] != '0) empty = 1'b0;
    end
  end

  assign bb_to_run = bb_q;
  assign run_count = run_count_q;
  assign run_valid = run_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bb_thread_sched.sv
module tb_bb_thread_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_sel;
  logic       choose_en;

  logic [4:0] bb0, bb1;
  logic [3:0] rc0, rc1;
  logic       rv0, rv1, em0, em1, of0, of1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit ev;
    int eb;
    int ec;
    bit eempty;
  } exp_t;

  typedef struct {
    bit we;
    int sel;
    bit ch;
    bit ev;
    int eb;
    int ec;
    bit eempty;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  bb_thread_sched #(.RR_MODE(0)) u_prio (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .choose_en(choose_en),
    .bb_to_run(bb0), .run_count(rc0), .run_valid(rv0), .empty(em0), .overflow(of0)
  );

  bb_thread_sched #(.RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .choose_en(choose_en),
    .bb_to_run(bb1), .run_count(rc1), .run_valid(rv1), .empty(em1), .overflow(of1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; returns #1 after the rising edge.
  task automatic step(input bit we, input int sel, input bit ch);
    wr_en     = we;
    wr_sel    = 5'(sel);
    choose_en = ch;
    @(posedge clk);
    #1;
    wr_en     = 1'b0;
    choose_en = 1'b0;
  endtask

  task automatic add_vec(input bit we, input int sel, input bit ch,
                         input bit ev, input int eb, input int ec, input bit eempty);
    vec_t v;
    v.we = we; v.sel = sel; v.ch = ch;
    v.ev = ev; v.eb = eb; v.ec = ec; v.eempty = eempty;
    vecs.push_back(v);
  endtask

  task automatic sb_push(input bit ev, input int eb, input int ec, input bit eempty);
    exp_t e;
    e.ev = ev; e.eb = eb; e.ec = ec; e.eempty = eempty;
    sb.push_back(e);
  endtask

  // Pop one expectation and compare against the priority-mode instance.
  task automatic sb_check(input string tag);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty got 1 expected 0", tag);
      return;
    end
    total--;
    e = sb.pop_front();
    check({tag, ".valid"}, int'(rv0), int'(e.ev));
    check({tag, ".bb"},    int'(bb0), e.eb);
    check({tag, ".count"}, int'(rc0), e.ec);
    check({tag, ".empty"}, int'(em0), int'(e.eempty));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = '0; choose_en = 1'b0;
    step(0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0);
    check("rst.bb",       int'(bb0), 0);
    check("rst.count",    int'(rc0), 0);
    check("rst.valid",    int'(rv0), 0);
    check("rst.empty",    int'(em0), 1);
    check("rst.overflow", int'(of0), 0);

    // Priority-mode vectors: {we, sel, ch} -> {valid, bb, count, empty} after the edge.
    add_vec(1, 7, 0, 0, 0, 0, 0);
    add_vec(1, 7 - 7, 0, 0, 0, 0, 0);  // BB 0 once more
    add_vec(0, 0, 1, 1, 0, 1, 0);      // lowest index wins
    add_vec(0, 0, 1, 1, 7, 1, 1);
    for (int i = 0; i < 6; i++) add_vec(1, 9, 0, 0, 7, 1, 0);
    for (int i = 0; i < 2; i++) add_vec(1, 3, 0, 0, 7, 1, 0);
    add_vec(0, 0, 1, 1, 3, 2, 0);
    add_vec(0, 0, 1, 1, 9, 4, 0);
    add_vec(0, 0, 1, 1, 9, 2, 1);
    add_vec(0, 0, 1, 0, 9, 0, 1);      // no candidate
    add_vec(1, 5, 1, 1, 5, 1, 1);      // same-cycle write+choose on empty
    add_vec(0, 0, 0, 0, 5, 1, 1);      // choose low: count holds
    for (int i = 0; i < 5; i++) add_vec(1, 6, 0, 0, 5, 1, 0);
    add_vec(1, 6, 1, 1, 6, 4, 0);      // post-write 6, grant 4
    add_vec(0, 0, 1, 1, 6, 2, 1);

    foreach (vecs[i]) begin
      sb_push(vecs[i].ev, vecs[i].eb, vecs[i].ec, vecs[i].eempty);
      step(vecs[i].we, vecs[i].sel, vecs[i].ch);
      sb_check($sformatf("vec%0d", i));
    end

    // Saturation on BB 2.
    for (int i = 0; i < 15; i++) step(1, 2, 0);
    check("sat.ovf_before", int'(of0), 0);
    step(1, 2, 0);
    check("sat.ovf_after", int'(of0), 1);
    sb_push(1, 2, 4, 0); step(0, 0, 1); sb_check("sat.c1");
    sb_push(1, 2, 4, 0); step(0, 0, 1); sb_check("sat.c2");
    sb_push(1, 2, 4, 0); step(0, 0, 1); sb_check("sat.c3");
    sb_push(1, 2, 3, 1); step(0, 0, 1); sb_check("sat.c4");
    check("sat.ovf_sticky", int'(of0), 1);

    // Reset in the same cycle as a choose with loaded counters.
    for (int i = 0; i < 3; i++) step(1, 8, 0);
    rst = 1'b1;
    step(0, 0, 1);
    rst = 1'b0;
    check("mrst.valid", int'(rv0), 0);
    check("mrst.bb",    int'(bb0), 0);
    check("mrst.count", int'(rc0), 0);
    check("mrst.empty", int'(em0), 1);
    check("mrst.ovf",   int'(of0), 0);
    check("mrst.rr_bb", int'(bb1), 0);
    step(0, 0, 1);
    check("mrst.nogrant",    int'(rv0), 0);
    check("mrst.rr_nogrant", int'(rv1), 0);

    // Round-robin instance: BBs 1, 4, 30 hold one thread each.
    step(1, 1, 0);
    step(1, 4, 0);
    step(1, 30, 0);
    step(0, 0, 1);
    check("rr.g1.valid", int'(rv1), 1);
    check("rr.g1.bb",    int'(bb1), 1);
    step(1, 1, 0);
    step(0, 0, 1);
    check("rr.g2.bb",    int'(bb1), 4);
    step(0, 0, 1);
    check("rr.g3.bb",    int'(bb1), 30);
    check("rr.g3.count", int'(rc1), 1);
    step(0, 0, 1);
    check("rr.g4.valid", int'(rv1), 1);
    check("rr.g4.bb",    int'(bb1), 1);
    check("rr.g4.empty", int'(em1), 1);
    step(0, 0, 1);
    check("rr.g5.valid", int'(rv1), 0);
    check("rr.g5.bb",    int'(bb1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
